// File: rtl/systolic_seq_ctrl_if.sv
// Command and array-control bundle of the systolic tile sequencer.
// The slave side is the sequencer; the master side issues commands and observes status.
interface systolic_seq_ctrl_if #(
  parameter int N      = 2,
  parameter int ROW_AW = 8,
  parameter int WB_AW  = 4
);
  logic                  start;
  logic                  abort;
  logic [ROW_AW-1:0]     num_rows;
  logic                  busy;
  logic                  done;
  logic                  wb_rd_en;
  logic [WB_AW-1:0]      wb_rd_addr;
  logic [N-1:0]          ub_rd_en;
  logic [N*ROW_AW-1:0]   ub_rd_addr;
  logic                  pe_enabled;
  logic [N-1:0]          pe_accept_w;
  logic [N-1:0]          pe_switch;
  logic [N-1:0]          pe_valid;

  modport master (
    output start, abort, num_rows,
    input  busy, done, wb_rd_en, wb_rd_addr, ub_rd_en, ub_rd_addr,
           pe_enabled, pe_accept_w, pe_switch, pe_valid
  );

  modport slave (
    input  start, abort, num_rows,
    output busy, done, wb_rd_en, wb_rd_addr, ub_rd_en, ub_rd_addr,
           pe_enabled, pe_accept_w, pe_switch, pe_valid
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for an N x N weight-stationary systolic array: weight load,
// swap, skewed input streaming and drain. All outputs are registered.
module systolic_seq_ctrl #(
  parameter int N      = 2,
  parameter int ROW_AW = 8,
  parameter int WB_AW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_seq_ctrl_if.slave   bus
);

  localparam int CW = ROW_AW + 1;
  localparam int XW = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SWITCH, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [ROW_AW-1:0]   m_reg, m_next;

  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                wb_en_reg, wb_en_next;
  logic [WB_AW-1:0]    wb_addr_reg, wb_addr_next;
  logic [N-1:0]        ub_en_reg, ub_en_next;
  logic [N*ROW_AW-1:0] ub_addr_reg, ub_addr_next;
  logic                pe_en_reg, pe_en_next;
  logic [N-1:0]        acc_reg, acc_next;
  logic [N-1:0]        sw_reg, sw_next;
  logic [N-1:0]        valid_reg, valid_next;

  logic [XW-1:0]       stream_last;
  logic [XW-1:0]       stream_last_next;
  logic [XW-1:0]       t_next;

  assign stream_last      = XW'(m_reg) + XW'(N - 1);
  assign stream_last_next = XW'(m_next) + XW'(N - 1);
  assign t_next           = XW'(cnt_next);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    m_next     = m_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          cnt_next = '0;
          if (bus.num_rows != '0) begin
            state_next = S_LOAD;
            m_next     = bus.num_rows;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (cnt_reg == CW'(N)) begin
          state_next = S_SWITCH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_SWITCH: begin
        state_next = S_STREAM;
        cnt_next   = '0;
      end
      S_STREAM: begin
        if (XW'(cnt_reg) == stream_last) begin
          state_next = S_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_reg == CW'(N - 1)) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (bus.abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end
  end

  // Outputs are decoded from the upcoming state so they line up with it once registered.
  always_comb begin
    busy_next    = (state_next != S_IDLE);
    done_next    = (state_next == S_DONE);
    pe_en_next   = (state_next == S_LOAD) || (state_next == S_SWITCH) ||
                   (state_next == S_STREAM) || (state_next == S_DRAIN);
    wb_en_next   = (state_next == S_LOAD) && (cnt_next < CW'(N));
    wb_addr_next = wb_en_next ? (WB_AW'(N - 1) - WB_AW'(cnt_next)) : '0;
    acc_next     = ((state_next == S_LOAD) && (cnt_next != '0)) ? '1 : '0;
    sw_next      = (state_next == S_SWITCH) ? '1 : '0;
    valid_next   = (state_next == S_IDLE) ? '0 : ub_en_reg;
  end

  // Row gi sees the input stream delayed by gi cycles (diagonal skew).
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      logic in_win;
      assign in_win = (state_next == S_STREAM) &&
                      (t_next >= XW'(gi)) &&
                      (t_next < XW'(gi) + XW'(m_next)) &&
                      (t_next < stream_last_next);
      assign ub_en_next[gi] = in_win;
      assign ub_addr_next[gi*ROW_AW +: ROW_AW] =
          in_win ? ROW_AW'(t_next - XW'(gi)) : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      m_reg       <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      ub_en_reg   <= '0;
      ub_addr_reg <= '0;
      pe_en_reg   <= 1'b0;
      acc_reg     <= '0;
      sw_reg      <= '0;
      valid_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      m_reg       <= m_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      wb_en_reg   <= wb_en_next;
      wb_addr_reg <= wb_addr_next;
      ub_en_reg   <= ub_en_next;
      ub_addr_reg <= ub_addr_next;
      pe_en_reg   <= pe_en_next;
      acc_reg     <= acc_next;
      sw_reg      <= sw_next;
      valid_reg   <= valid_next;
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.wb_rd_en    = wb_en_reg;
  assign bus.wb_rd_addr  = wb_addr_reg;
  assign bus.ub_rd_en    = ub_en_reg;
  assign bus.ub_rd_addr  = ub_addr_reg;
  assign bus.pe_enabled  = pe_en_reg;
  assign bus.pe_accept_w = acc_reg;
  assign bus.pe_switch   = sw_reg;
  assign bus.pe_valid    = valid_reg;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (N=2): cycle-by-cycle vector table for a
// 3-row tile plus hand sequences for reset, empty tile, abort and ignored start.
module tb_systolic_seq_ctrl;

  localparam int N      = 2;
  localparam int ROW_AW = 8;
  localparam int WB_AW  = 4;
  localparam int NCYC   = 14;

  logic clk;
  logic rst;

  systolic_seq_ctrl_if #(.N(N), .ROW_AW(ROW_AW), .WB_AW(WB_AW)) bus ();

  systolic_seq_ctrl #(.N(N), .ROW_AW(ROW_AW), .WB_AW(WB_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  nr;
    logic        abort;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [NCYC];
  int   tests = 0;
  int   fails = 0;

  // {busy, done, wb_en, wb_addr, ub_en, ub_addr1, ub_addr0, pe_en, accept_w, switch, valid}
  function automatic logic [31:0] ev(input logic b, input logic d, input logic we,
                                     input logic [3:0] wa, input logic [1:0] ue,
                                     input logic [7:0] a0, input logic [7:0] a1,
                                     input logic pe, input logic [1:0] acc,
                                     input logic [1:0] sw, input logic [1:0] v);
    return {b, d, we, wa, ue, a1, a0, pe, acc, sw, v};
  endfunction

  function automatic logic [31:0] act_vec();
    return {bus.busy, bus.done, bus.wb_rd_en, bus.wb_rd_addr, bus.ub_rd_en,
            bus.ub_rd_addr, bus.pe_enabled, bus.pe_accept_w, bus.pe_switch, bus.pe_valid};
  endfunction

  function automatic vec_t row(input logic s, input logic [7:0] nr, input logic [31:0] e);
    vec_t r;
    r.start = s;
    r.nr    = nr;
    r.abort = 1'b0;
    r.exp   = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] nr, input logic a);
    bus.start    = s;
    bus.num_rows = nr;
    bus.abort    = a;
  endtask

  // Apply the tile table; inject=1 pulses start with num_rows=7 mid-STREAM.
  task automatic run_table(input string tag, input bit inject);
    int busy_cnt = 0;
    int done_cnt = 0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d", tag, i), act_vec(), tbl[i].exp);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      if (inject && i == 6) drive(1'b1, 8'd7, 1'b0);
      else                  drive(tbl[i].start, tbl[i].nr, tbl[i].abort);
    end
    drive(1'b0, 8'd0, 1'b0);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd12);
    chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  logic [31:0] sticky;

  initial begin
    tbl[0]  = row(1'b1, 8'd3, ev(0,0,0,0,0,0,0,0,0,0,0));
    tbl[1]  = row(1'b0, 8'd0, ev(1,0,1,1,0,0,0,1,0,0,0));
    tbl[2]  = row(1'b0, 8'd0, ev(1,0,1,0,0,0,0,1,3,0,0));
    tbl[3]  = row(1'b0, 8'd0, ev(1,0,0,0,0,0,0,1,3,0,0));
    tbl[4]  = row(1'b0, 8'd0, ev(1,0,0,0,0,0,0,1,0,3,0));
    tbl[5]  = row(1'b0, 8'd0, ev(1,0,0,0,1,0,0,1,0,0,0));
    tbl[6]  = row(1'b0, 8'd0, ev(1,0,0,0,3,1,0,1,0,0,1));
    tbl[7]  = row(1'b0, 8'd0, ev(1,0,0,0,3,2,1,1,0,0,3));
    tbl[8]  = row(1'b0, 8'd0, ev(1,0,0,0,2,0,2,1,0,0,3));
    tbl[9]  = row(1'b0, 8'd0, ev(1,0,0,0,0,0,0,1,0,0,2));
    tbl[10] = row(1'b0, 8'd0, ev(1,0,0,0,0,0,0,1,0,0,0));
    tbl[11] = row(1'b0, 8'd0, ev(1,0,0,0,0,0,0,1,0,0,0));
    tbl[12] = row(1'b0, 8'd0, ev(1,1,0,0,0,0,0,0,0,0,0));
    tbl[13] = row(1'b0, 8'd0, ev(0,0,0,0,0,0,0,0,0,0,0));

    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_state", act_vec(), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_table("tile", 1'b0);

    // Async reset in STREAM t=2 (M=4): outputs clear without a clock edge.
    @(negedge clk);
    drive(1'b1, 8'd4, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0);
    repeat (6) @(negedge clk);
    chk("rst_pre_ub_en", 32'(bus.ub_rd_en), 32'd3);
    #1 rst = 1'b0;
    #1 chk("rst_async_clear", act_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_after_idle", act_vec(), 32'd0);

    // Empty tile: done one cycle after start, no array activity.
    sticky = '0;
    drive(1'b1, 8'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0);
    chk("zero_rows_done", act_vec(), ev(1,1,0,0,0,0,0,0,0,0,0));
    sticky |= 32'({bus.pe_accept_w, bus.pe_switch, bus.pe_valid});
    @(negedge clk);
    chk("zero_rows_idle", act_vec(), 32'd0);
    sticky |= 32'({bus.pe_accept_w, bus.pe_switch, bus.pe_valid});
    chk("zero_rows_no_array", sticky, 32'd0);

    // Abort at LOAD k=1, then a full tile must still run.
    sticky = '0;
    drive(1'b1, 8'd3, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0);
    sticky |= 32'(bus.done);
    @(negedge clk);
    chk("abort_at_load_k1", act_vec(), tbl[2].exp);
    drive(1'b0, 8'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0);
    chk("abort_to_idle", act_vec(), 32'd0);
    sticky |= 32'(bus.done);
    @(negedge clk);
    sticky |= 32'(bus.done);
    chk("abort_no_done", sticky, 32'd0);
    run_table("post_abort", 1'b0);

    run_table("start_in_stream", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N weight-stationary systolic array of Q8.8 PEs with double-buffered weights.
- On `start` it runs four phases in order: shifts one weight tile into the inactive weight registers, pulses switch, streams M input vectors with diagonal skew, then waits for the array to drain.
- It drives only the control signals and the buffer read addresses. Weight and input data go straight from the buffers to the array.
- It sits between the top-level command interface and the array plus its weight and unified buffers.

Parameters:
- N, 2, array dimension (rows = columns = N).
- ROW_AW, 8, width of the input-row address and of num_rows.
- WB_AW, 4, weight buffer address width; must satisfy 2^WB_AW >= N.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; all state cleared while low.
- start  in  1  begin one tile operation; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE with no done pulse.
- num_rows  in  ROW_AW  number of input vectors M; sampled with start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- wb_rd_en  out  1  weight buffer read enable; buffer read latency is 1 cycle.
- wb_rd_addr  out  WB_AW  weight buffer row address.
- ub_rd_en  out  N  per-array-row input buffer read enable; read latency is 1 cycle.
- ub_rd_addr  out  N*ROW_AW  per-row input address; row i occupies bits [i*ROW_AW +: ROW_AW].
- pe_enabled  out  1  array enable.
- pe_accept_w  out  N  per-column weight shift enable.
- pe_switch  out  N  per-column inactive-to-active weight swap.
- pe_valid  out  N  per-row input valid into the west edge of the array.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; every output = 0 immediately, not at the next edge.
- States and transitions: IDLE -> LOAD -> SWITCH -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 and num_rows>0: latch M = num_rows, go to LOAD.
  - start=1 and num_rows=0: go directly to DONE; no array signal is asserted.
- LOAD, N+1 cycles, local counter k = 0..N:
  - k<N: wb_rd_en=1, wb_rd_addr = N-1-k, so the bottom row's weights enter first.
  - k>=1: pe_accept_w = all ones, capturing the buffer data read the previous cycle.
  - After the last cycle, the weight for array row r sits in PE row r's inactive register.
- SWITCH, 1 cycle: pe_switch = all ones; pe_accept_w = 0.
- STREAM, M+N cycles, counter t = 0..M+N-1:
  - ub_rd_en[i] = 1 iff i <= t < i+M and t < M+N-1.
  - ub_rd_addr[i] = t-i while enabled, else 0.
  - pe_valid[i] = ub_rd_en[i] registered by one cycle.
- DRAIN, N cycles: all enables 0; lets the psums exit the bottom row.
- DONE, 1 cycle: done=1, busy=1.
- pe_enabled = 1 in LOAD, SWITCH, STREAM and DRAIN; 0 otherwise.
- busy = 1 in every state except IDLE.
- Total busy cycles = M + 3N + 3.
- start while busy is ignored; num_rows changes while busy have no effect.
- abort, in any non-IDLE state: next cycle is IDLE with all outputs 0; done is not asserted. abort in IDLE is ignored.
- abort and start in the same IDLE cycle: start wins.
- Counters never wrap: t tops out at M+N-1 <= 2^ROW_AW+N-2; the internal counter is ROW_AW+1 bits wide.
- pe_valid is a true registered copy: a read enable in the last STREAM cycle would still emit pe_valid in the first DRAIN cycle. By construction no enable is issued in that cycle.

Test Plan:
- Reset mid-STREAM (N=2, M=4): drop rst at STREAM t=2 -> all outputs 0 in the same cycle, before any clock edge. After release, state is IDLE and busy=0.
- Basic tile (N=2, M=3), start at cycle 0:
  - cycles 1-3: LOAD, wb_rd_addr = 1, 0, then wb_rd_en low; pe_accept_w = 2'b11 in cycles 2-3.
  - cycle 4: pe_switch = 2'b11.
  - cycles 5-9: STREAM. ub_rd_en[0] high in cycles 5-7 (addr 0, 1, 2); ub_rd_en[1] high in cycles 6-8 (addr 0, 1, 2).
  - pe_valid[0] high in cycles 6-8; pe_valid[1] high in cycles 7-9.
  - cycles 10-11: DRAIN. Cycle 12: done. busy high for 12 cycles.
- Integrated with pe array, weights {4.34765625, 10.6015625} and inputs {2.0, -3.3984375, 19.359375} -> bottom psums match the Q8.8 golden model bit-exactly.
- num_rows=0 -> done one cycle after start; pe_accept_w, pe_switch and pe_valid never asserted.
- abort at LOAD k=1 -> IDLE next cycle, done never asserted. A following start runs the full 12-cycle sequence.
- start pulsed in STREAM with num_rows=7 -> ignored; the sequence completes with M=3 and the cycle counts are unchanged.
